// File: rtl/serial_operand_loader_pkg.sv
// Shared constants and output-FSM encoding for the bit-serial operand loader.
// Bit order is selected at build time by SERLOAD_MSB_FIRST_EN (see ser_shift_lane).
package serial_operand_loader_pkg;

    localparam int D_N_DEFAULT = 32;
    localparam int BITCNT_W    = $clog2(D_N_DEFAULT);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } out_state_t;

    // Bit-counter width for an arbitrary operand width.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_operand_loader_ser_shift_lane.sv
// One serial-in shift lane with enable and frame-restart clear.
// SERLOAD_MSB_FIRST_EN defined: MSB-first shift-left; otherwise LSB-first shift-right.
module ser_shift_lane
    import serial_operand_loader_pkg::*;
#(
    parameter int D_N = D_N_DEFAULT
) (
    input  logic           w_clk,
    input  logic           w_rst,
    input  logic           w_en,
    input  logic           w_clr,
    input  logic           w_din,
    output logic [D_N-1:0] w_lane,
    output logic [D_N-1:0] w_lane_next
);

    logic [D_N-1:0] lane_reg;
    logic [D_N-1:0] shifted;

    // On a frame restart the stale bits are zeroed so the new bit starts alone.
    for (genvar gi = 0; gi < D_N; gi++) begin : g_bit
`ifdef SERLOAD_MSB_FIRST_EN
        if (gi == 0) begin : g_in
            assign shifted[gi] = w_din;
        end else begin : g_mid
            assign shifted[gi] = w_clr ? 1'b0 : lane_reg[gi-1];
        end
`else
        if (gi == D_N - 1) begin : g_in
            assign shifted[gi] = w_din;
        end else begin : g_mid
            assign shifted[gi] = w_clr ? 1'b0 : lane_reg[gi+1];
        end
`endif
    end

    always_comb begin
        w_lane_next = lane_reg;
        if (w_en) begin
            w_lane_next = shifted;
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            lane_reg <= '0;
        end else begin
            lane_reg <= w_lane_next;
        end
    end

    assign w_lane = lane_reg;

endmodule

// File: rtl/serial_operand_loader.sv
// Bit-serial to parallel operand loader with a one-entry holding register and sticky overrun.
// Bit order follows SERLOAD_MSB_FIRST_EN inside ser_shift_lane; control logic is order-agnostic.
module serial_operand_loader
    import serial_operand_loader_pkg::*;
#(
    parameter int D_N = D_N_DEFAULT
) (
    input  logic                      w_clk,
    input  logic                      w_rst,
    input  logic                      w_sin_a,
    input  logic                      w_sin_b,
    input  logic                      w_sin_vld,
    input  logic                      w_sof,
    output logic [D_N-1:0]            w_opa,
    output logic [D_N-1:0]            w_opb,
    output logic                      w_ovld,
    input  logic                      w_ordy,
    output logic                      w_ovf,
    output logic [cnt_width(D_N)-1:0] w_bitcnt
);

    localparam int CNT_W = cnt_width(D_N);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             frame_done;
    logic [D_N-1:0]   lane_a, lane_b;
    logic [D_N-1:0]   lane_a_next, lane_b_next;
    logic [D_N-1:0]   opa_reg, opb_reg;
    logic             ovf_reg;
    out_state_t       state_reg, state_next;
    logic             hold_load;
    logic             ovf_set;

    ser_shift_lane #(.D_N(D_N)) u_lane_a (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .w_en        (w_sin_vld),
        .w_clr       (w_sof),
        .w_din       (w_sin_a),
        .w_lane      (lane_a),
        .w_lane_next (lane_a_next)
    );

    ser_shift_lane #(.D_N(D_N)) u_lane_b (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .w_en        (w_sin_vld),
        .w_clr       (w_sof),
        .w_din       (w_sin_b),
        .w_lane      (lane_b),
        .w_lane_next (lane_b_next)
    );

    // A start-of-frame strobe is always bit 0 of a new frame, never a completion.
    always_comb begin
        cnt_next   = cnt_reg;
        frame_done = 1'b0;
        if (w_sin_vld) begin
            if (w_sof) begin
                cnt_next = CNT_W'(1);
            end else if (cnt_reg == CNT_W'(D_N - 1)) begin
                cnt_next   = '0;
                frame_done = 1'b1;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_reg <= S_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_EMPTY: if (frame_done)            state_next = S_FULL;
            S_FULL:  if (w_ordy && !frame_done) state_next = S_EMPTY;
            default:                            state_next = S_EMPTY;
        endcase
    end

    // A handshake in the completion cycle frees the slot, so the new frame reloads it.
    always_comb begin
        hold_load = 1'b0;
        ovf_set   = 1'b0;
        if (frame_done) begin
            if (state_reg == S_EMPTY || w_ordy) begin
                hold_load = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            cnt_reg <= '0;
            opa_reg <= '0;
            opb_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if (hold_load) begin
                opa_reg <= lane_a_next;
                opb_reg <= lane_b_next;
            end
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign w_opa    = opa_reg;
    assign w_opb    = opb_reg;
    assign w_ovld   = (state_reg == S_FULL);
    assign w_ovf    = ovf_reg;
    assign w_bitcnt = cnt_reg;

endmodule

// File: tb/tb_serial_operand_loader.sv
// Randomized self-checking bench for serial_operand_loader with a queue-based frame model.
// Follows SERLOAD_MSB_FIRST_EN for the expected bit order.
module tb_serial_operand_loader;
    import serial_operand_loader_pkg::*;

    localparam int DN = 32;
    localparam int CW = $clog2(DN);

    logic          w_clk = 1'b0;
    logic          w_rst = 1'b0;
    logic          w_sin_a = 1'b0;
    logic          w_sin_b = 1'b0;
    logic          w_sin_vld = 1'b0;
    logic          w_sof = 1'b0;
    logic          w_ordy = 1'b0;
    logic [DN-1:0] w_opa, w_opb;
    logic          w_ovld, w_ovf;
    logic [CW-1:0] w_bitcnt;

    serial_operand_loader #(.D_N(DN)) dut (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .w_sin_a   (w_sin_a),
        .w_sin_b   (w_sin_b),
        .w_sin_vld (w_sin_vld),
        .w_sof     (w_sof),
        .w_opa     (w_opa),
        .w_opb     (w_opb),
        .w_ovld    (w_ovld),
        .w_ordy    (w_ordy),
        .w_ovf     (w_ovf),
        .w_bitcnt  (w_bitcnt)
    );

    always #5 w_clk = ~w_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: bits of the partial frame in arrival order plus one held frame.
    bit            qa[$];
    bit            qb[$];
    logic          m_vld;
    logic          m_ovf;
    logic [DN-1:0] m_opa, m_opb;

    function automatic logic [DN-1:0] assemble(input bit q[$]);
        logic [DN-1:0] v;
        v = '0;
        for (int i = 0; i < q.size(); i++) begin
`ifdef SERLOAD_MSB_FIRST_EN
            v[DN-1-i] = q[i];
`else
            v[i] = q[i];
`endif
        end
        return v;
    endfunction

    // The i-th bit to put on the wire so the frame assembles to v.
    function automatic bit send_bit(input logic [DN-1:0] v, input int i);
`ifdef SERLOAD_MSB_FIRST_EN
        return v[DN-1-i];
`else
        return v[i];
`endif
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_vld = 1'b0;
        m_ovf = 1'b0;
        m_opa = '0;
        m_opb = '0;
    endtask

    task automatic model_step(input bit a, input bit b, input bit vld, input bit sof, input bit ordy);
        bit            done;
        logic [DN-1:0] fa, fb;
        done = 1'b0;
        fa   = '0;
        fb   = '0;
        if (vld) begin
            if (sof) begin
                qa.delete();
                qb.delete();
            end
            qa.push_back(a);
            qb.push_back(b);
            if (qa.size() == DN) begin
                done = 1'b1;
                fa   = assemble(qa);
                fb   = assemble(qb);
                qa.delete();
                qb.delete();
            end
        end
        if (m_vld && ordy) m_vld = 1'b0;
        if (done) begin
            if (!m_vld) begin
                m_vld = 1'b1;
                m_opa = fa;
                m_opb = fb;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cycle(input bit a, input bit b, input bit vld, input bit sof, input bit ordy);
        w_sin_a   = a;
        w_sin_b   = b;
        w_sin_vld = vld;
        w_sof     = sof;
        w_ordy    = ordy;
        @(posedge w_clk);
        model_step(a, b, vld, sof, ordy);
        #1;
    endtask

    // Strobes are held active during reset to confirm they are ignored.
    task automatic do_reset();
        w_rst     = 1'b1;
        w_sin_vld = 1'b1;
        w_sin_a   = 1'b1;
        w_sin_b   = 1'b1;
        w_sof     = 1'b0;
        w_ordy    = 1'b0;
        @(posedge w_clk);
        model_reset();
        #1;
        w_rst     = 1'b0;
        w_sin_vld = 1'b0;
    endtask

    task automatic send_frame(input logic [DN-1:0] a, input logic [DN-1:0] b,
                              input bit ordy_body, input bit ordy_last);
        for (int i = 0; i < DN; i++) begin
            cycle(send_bit(a, i), send_bit(b, i), 1'b1, 1'b0, (i == DN - 1) ? ordy_last : ordy_body);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) cycle(1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
        do_reset();
        n_cmp++;
        if ({w_opa, w_opb, w_ovld, w_ovf, w_bitcnt} !== {(2*DN+2+CW){1'b0}}) begin
            n_fail++;
            $display("FAIL reset: opa=%h opb=%h ovld=%b ovf=%b bitcnt=%0d, required all zero",
                     w_opa, w_opb, w_ovld, w_ovf, w_bitcnt);
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < DN; i++) begin
            cycle(send_bit(32'h0000_0005, i), send_bit(32'h0000_0003, i), 1'b1, 1'b0, 1'b1);
            if (i < DN - 1) begin
                n_cmp++;
                if (w_ovld !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_early_ovld: strobe %0d ovld=%b required 0", i, w_ovld);
                end
            end
        end
        n_cmp++;
        if ({w_ovld, w_opa, w_opb, w_bitcnt} !== {1'b1, 32'h0000_0005, 32'h0000_0003, CW'(0)}) begin
            n_fail++;
            $display("FAIL basic_frame: ovld=%b opa=%h opb=%h bitcnt=%0d, required 1/00000005/00000003/0",
                     w_ovld, w_opa, w_opb, w_bitcnt);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (w_ovld !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_one_cycle: ovld=%b required 0", w_ovld);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        send_frame(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        n_cmp++;
        if ({w_ovld, w_opa, w_opb, w_ovf} !== {1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0}) begin
            n_fail++;
            $display("FAIL overrun_first: ovld=%b opa=%h opb=%h ovf=%b, required 1/ffffffff/00000001/0",
                     w_ovld, w_opa, w_opb, w_ovf);
        end
        send_frame(32'h0000_0007, 32'h0000_0009, 1'b0, 1'b0);
        n_cmp++;
        if ({w_ovld, w_opa, w_opb, w_ovf} !== {1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1}) begin
            n_fail++;
            $display("FAIL overrun_second: ovld=%b opa=%h opb=%h ovf=%b, required 1/ffffffff/00000001/1",
                     w_ovld, w_opa, w_opb, w_ovf);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({w_ovld, w_ovf} !== 2'b01) begin
            n_fail++;
            $display("FAIL overrun_drain: ovld=%b ovf=%b, required 0/1", w_ovld, w_ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic [DN-1:0] ra, rb, na, nb;
        do_reset();
        ra = $urandom;
        rb = $urandom;
        na = $urandom;
        nb = $urandom;
        send_frame(ra, rb, 1'b0, 1'b0);
        n_cmp++;
        if ({w_ovld, w_opa, w_opb} !== {1'b1, ra, rb}) begin
            n_fail++;
            $display("FAIL b2b_first: ovld=%b opa=%h opb=%h, required 1/%h/%h", w_ovld, w_opa, w_opb, ra, rb);
        end
        send_frame(na, nb, 1'b0, 1'b1);
        n_cmp++;
        if ({w_ovld, w_opa, w_opb, w_ovf} !== {1'b1, na, nb, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_reload: ovld=%b opa=%h opb=%h ovf=%b, required 1/%h/%h/0",
                     w_ovld, w_opa, w_opb, w_ovf, na, nb);
        end
    endtask

    task automatic test_sof();
        logic [DN-1:0] fa, fb;
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (w_bitcnt !== CW'(10)) begin
            n_fail++;
            $display("FAIL sof_partial: bitcnt=%0d required 10", w_bitcnt);
        end
        fa = $urandom;
        fb = $urandom;
        for (int i = 0; i < DN; i++) begin
            cycle(send_bit(fa, i), send_bit(fb, i), 1'b1, i == 0, 1'b1);
            if (i == 0) begin
                n_cmp++;
                if (w_bitcnt !== CW'(1)) begin
                    n_fail++;
                    $display("FAIL sof_bitcnt: bitcnt=%0d required 1", w_bitcnt);
                end
            end
        end
        n_cmp++;
        if ({w_ovld, w_opa, w_opb} !== {1'b1, fa, fb}) begin
            n_fail++;
            $display("FAIL sof_frame: ovld=%b opa=%h opb=%h, required 1/%h/%h", w_ovld, w_opa, w_opb, fa, fb);
        end
    endtask

    task automatic test_reset_mid();
        logic [DN-1:0] xa, xb;
        do_reset();
        send_frame($urandom, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
        do_reset();
        n_cmp++;
        if ({w_opa, w_opb, w_ovld, w_ovf, w_bitcnt} !== {(2*DN+2+CW){1'b0}}) begin
            n_fail++;
            $display("FAIL reset_mid: opa=%h opb=%h ovld=%b ovf=%b bitcnt=%0d, required all zero",
                     w_opa, w_opb, w_ovld, w_ovf, w_bitcnt);
        end
        xa = $urandom;
        xb = $urandom;
        send_frame(xa, xb, 1'b1, 1'b1);
        n_cmp++;
        if ({w_ovld, w_opa, w_opb, w_bitcnt} !== {1'b1, xa, xb, CW'(0)}) begin
            n_fail++;
            $display("FAIL reset_mid_frame: ovld=%b opa=%h opb=%h bitcnt=%0d, required 1/%h/%h/0",
                     w_ovld, w_opa, w_opb, w_bitcnt, xa, xb);
        end
    endtask

    task automatic test_bit_order();
        logic [DN-1:0] exp_a;
`ifdef SERLOAD_MSB_FIRST_EN
        exp_a = 32'h8000_0000;
`else
        exp_a = 32'h0000_0001;
`endif
        do_reset();
        for (int i = 0; i < DN; i++) cycle(i == 0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({w_ovld, w_opa, w_opb} !== {1'b1, exp_a, 32'h0}) begin
            n_fail++;
            $display("FAIL bit_order: ovld=%b opa=%h opb=%h, required 1/%h/00000000", w_ovld, w_opa, w_opb, exp_a);
        end
    endtask

    task automatic test_random();
        bit vld, sof, ordy;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            vld  = ($urandom_range(0, 9) < 8);
            sof  = ($urandom_range(0, 59) == 0);
            ordy = (c >= 900 && c < 1100) ? ($urandom_range(0, 19) == 0) : 1'($urandom);
            cycle(1'($urandom), 1'($urandom), vld, sof, ordy);
            n_cmp++;
            if ({w_ovld, w_ovf, w_bitcnt} !== {m_vld, m_ovf, CW'(qa.size())}) begin
                n_fail++;
                $display("FAIL rand_ctrl: cycle %0d ovld=%b ovf=%b bitcnt=%0d, required %b/%b/%0d",
                         c, w_ovld, w_ovf, w_bitcnt, m_vld, m_ovf, qa.size());
            end
            if (m_vld) begin
                n_cmp++;
                if ({w_opa, w_opb} !== {m_opa, m_opb}) begin
                    n_fail++;
                    $display("FAIL rand_data: cycle %0d opa=%h opb=%h, required %h/%h",
                             c, w_opa, w_opb, m_opa, m_opb);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_sof();
        test_reset_mid();
        test_bit_order();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
